ttt_referee: RTL and testbench
==============================

Name: ttt_referee

Overview:
Reader side of the tic-tac-toe cell interface. It consumes the valid/symbol outputs of the nine board cells and judges the board.
- On a start pulse it snapshots the board and scans the 8 winning lines sequentially, one line per cycle.
- It reports win (with symbol and line), draw, or nothing, and signals done for one cycle.
- It sits beside the 9-cell board array and feeds the game controller.

Parameters:
FIRST_SYMBOL, 0, symbol value of the player who moves first; used only by the optional legality check.

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request a board judgement; accepted only when busy=0
valid  input  9  cell occupied flags; bit i = cell i, i = row*3+col
symbol  input  9  cell symbols; bit i = cell i; meaningful only where valid[i]=1
busy  output  1  scan in progress
done  output  1  one-cycle pulse when the result registers are updated
winner_valid  output  1  a winning line was found
winner  output  1  symbol of the winning line
win_line  output  3  index of the winning line
draw  output  1  all 9 cells valid and no win
illegal  output  1  board fails the legality check (optional feature; tied 0 otherwise)

Behaviour:
- Reset: synchronous, active-high, has priority over everything. State goes to IDLE. busy, done, winner_valid, winner, win_line, draw and illegal all go to 0.
- Reset during SCAN or CHECK_DRAW aborts the scan; no done pulse is produced.
- States: IDLE, SCAN, CHECK_DRAW, DONE.
- IDLE or DONE, start=1 at an edge (call it edge 0):
  - Register the snapshot of valid/symbol. Later input changes are ignored until the next start.
  - Clear result registers, set line index to 0, go to SCAN, busy=1.
- start is ignored while busy=1.
- Line table:
  - Rows: 0={0,1,2}, 1={3,4,5}, 2={6,7,8}.
  - Columns: 3={0,3,6}, 4={1,4,7}, 5={2,5,8}.
  - Diagonals: 6={0,4,8}, 7={2,4,6}.
- A line matches when all three snapshot valid bits are 1 and all three symbols are equal.
- SCAN, one line per edge:
  - If line k matches at edge k+1: set winner_valid=1, winner=symbol, win_line=k, done=1, busy=0, go to DONE.
  - Otherwise increment the index. After line 7 fails (edge 8), go to CHECK_DRAW.
  - The lowest-index matching line wins.
- CHECK_DRAW (edge 9): draw = (snapshot valid == 9'h1FF). Set done=1, busy=0, go to DONE.
- DONE:
  - done is high for exactly one cycle; at the next edge it drops and the state goes to IDLE.
  - If start is high at that edge, a new scan begins instead.
  - Result outputs hold until the next accepted start or reset.
- Latency from the start edge:
  - Win on line k: done high after edge k+1.
  - No win: done high after edge 9.
- Reset and start on the same edge: reset wins.

Optional Feature:
TTT_REFEREE_ILLEGAL_CHECK_EN
- Defined:
  - At the snapshot edge, count valid cells holding FIRST_SYMBOL (cf) and holding ~FIRST_SYMBOL (cs).
  - The board is legal only if cf-cs is 0 or 1.
  - Illegal board: at edge 1 set illegal=1, winner_valid=0, draw=0, done=1, and go to DONE, skipping the scan.
- Not defined: illegal is constant 0 and no counting logic is built.

Decomposition:
- Shared include ttt_defs.v holds:
  - NUM_CELLS=9 and NUM_LINES=8;
  - the state encodings;
  - the 8x3 line-to-cell index table.
- One natural sub-module, ttt_line_check: combinational; takes three (valid, symbol) pairs and returns match and symbol. It is instantiated once, with cells muxed by line index.

Test Plan:
1. Row-0 win: valid=9'b000011111, symbol=9'b000011000, start → done after edge 1, winner_valid=1, winner=0, win_line=0, draw=0.
2. Anti-diagonal win: valid=9'b001010111, symbol=9'b000000011, start → done after edge 8, winner=0, win_line=7; busy=1 during edges 0-7.
3. Draw: valid=9'h1FF, symbol=9'b001110010, start → done after edge 9, draw=1, winner_valid=0.
4. Snapshot: start on an empty board, then drive the test-1 board at edge 2 → done after edge 9, draw=0, winner_valid=0.
5. Reset mid-scan: start on the test-2 board, reset at edge 3 → no done, all outputs 0, busy=0; a new start then completes normally.
6. With TTT_REFEREE_ILLEGAL_CHECK_EN defined: valid=9'b000000111, symbol=9'b000000111 → done after edge 1, illegal=1, winner_valid=0. Without the macro, the same board gives winner=1, win_line=0.

Source files
------------

// File: rtl/ttt_referee_pkg.sv
// Shared definitions for the tic-tac-toe referee: sizes, FSM encoding, line table.
// Optional legality check macro: TTT_REFEREE_ILLEGAL_CHECK_EN.
package ttt_referee_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SCAN       = 2'd1,
        ST_CHECK_DRAW = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    // Returns {cell2, cell1, cell0} for a winning line, 4 bits per cell index.
    function automatic logic [11:0] line_cells(input logic [2:0] line);
        logic [11:0] cells;
        case (line)
            3'd0:    cells = {4'd2, 4'd1, 4'd0};
            3'd1:    cells = {4'd5, 4'd4, 4'd3};
            3'd2:    cells = {4'd8, 4'd7, 4'd6};
            3'd3:    cells = {4'd6, 4'd3, 4'd0};
            3'd4:    cells = {4'd7, 4'd4, 4'd1};
            3'd5:    cells = {4'd8, 4'd5, 4'd2};
            3'd6:    cells = {4'd8, 4'd4, 4'd0};
            3'd7:    cells = {4'd6, 4'd4, 4'd2};
            default: cells = {4'd2, 4'd1, 4'd0};
        endcase
        return cells;
    endfunction

    function automatic logic [3:0] popcount9(input logic [8:0] bits);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            cnt = cnt + {3'd0, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational match test for one three-cell line of the board.
module ttt_line_check (
    input  logic v0,
    input  logic s0,
    input  logic v1,
    input  logic s1,
    input  logic v2,
    input  logic s2,
    output logic match,
    output logic sym
);

    assign match = v0 & v1 & v2 & (s0 == s1) & (s1 == s2);
    assign sym   = s0;

endmodule

// File: rtl/ttt_referee.sv
// Board judge: snapshots the 9 cells on start and scans the 8 lines, one per cycle.
// Optional legality check enabled by defining TTT_REFEREE_ILLEGAL_CHECK_EN.
module ttt_referee #(
    parameter logic FIRST_SYMBOL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] valid,
    input  logic [8:0] symbol,
    output logic       busy,
    output logic       done,
    output logic       winner_valid,
    output logic       winner,
    output logic [2:0] win_line,
    output logic       draw,
    output logic       illegal
);

    import ttt_referee_pkg::*;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [8:0] snap_valid_q, snap_valid_d;
    logic [8:0] snap_symbol_q, snap_symbol_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       winner_valid_q, winner_valid_d;
    logic       winner_q, winner_d;
    logic [2:0] win_line_q, win_line_d;
    logic       draw_q, draw_d;
    logic       illegal_q, illegal_d;

    logic [11:0] cells_s;
    logic [3:0]  c0_s, c1_s, c2_s;
    logic        match_s, match_sym_s;
    logic        bad_board_s;

    assign cells_s = line_cells(idx_q);
    assign c0_s    = cells_s[3:0];
    assign c1_s    = cells_s[7:4];
    assign c2_s    = cells_s[11:8];

    ttt_line_check u_line_check (
        .v0    (snap_valid_q[c0_s]),
        .s0    (snap_symbol_q[c0_s]),
        .v1    (snap_valid_q[c1_s]),
        .s1    (snap_symbol_q[c1_s]),
        .v2    (snap_valid_q[c2_s]),
        .s2    (snap_symbol_q[c2_s]),
        .match (match_s),
        .sym   (match_sym_s)
    );

`ifdef TTT_REFEREE_ILLEGAL_CHECK_EN
    logic [3:0] cnt_first_s, cnt_second_s;
    // Legal boards have the first mover at most one stone ahead.
    assign cnt_first_s  = popcount9(snap_valid_q & ~(snap_symbol_q ^ {9{FIRST_SYMBOL}}));
    assign cnt_second_s = popcount9(snap_valid_q & (snap_symbol_q ^ {9{FIRST_SYMBOL}}));
    assign bad_board_s  = !((cnt_first_s == cnt_second_s) ||
                            (cnt_first_s == (cnt_second_s + 4'd1)));
`else
    logic unused_first_symbol_s;
    assign unused_first_symbol_s = FIRST_SYMBOL;
    assign bad_board_s           = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        snap_valid_d   = snap_valid_q;
        snap_symbol_d  = snap_symbol_q;
        busy_d         = busy_q;
        done_d         = done_q;
        winner_valid_d = winner_valid_q;
        winner_d       = winner_q;
        win_line_d     = win_line_q;
        draw_d         = draw_q;
        illegal_d      = illegal_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done_d = 1'b0;
                if (start) begin
                    snap_valid_d   = valid;
                    snap_symbol_d  = symbol;
                    winner_valid_d = 1'b0;
                    winner_d       = 1'b0;
                    win_line_d     = 3'd0;
                    draw_d         = 1'b0;
                    illegal_d      = 1'b0;
                    idx_d          = 3'd0;
                    busy_d         = 1'b1;
                    state_d        = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if ((idx_q == 3'd0) && bad_board_s) begin
                    illegal_d      = 1'b1;
                    winner_valid_d = 1'b0;
                    draw_d         = 1'b0;
                    done_d         = 1'b1;
                    busy_d         = 1'b0;
                    state_d        = ST_DONE;
                end else if (match_s) begin
                    winner_valid_d = 1'b1;
                    winner_d       = match_sym_s;
                    win_line_d     = idx_q;
                    done_d         = 1'b1;
                    busy_d         = 1'b0;
                    state_d        = ST_DONE;
                end else if (idx_q == 3'd7) begin
                    state_d = ST_CHECK_DRAW;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_CHECK_DRAW: begin
                draw_d  = (snap_valid_q == 9'h1FF);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= 3'd0;
            snap_valid_q   <= 9'd0;
            snap_symbol_q  <= 9'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_q       <= 1'b0;
            win_line_q     <= 3'd0;
            draw_q         <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            snap_valid_q   <= snap_valid_d;
            snap_symbol_q  <= snap_symbol_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            winner_valid_q <= winner_valid_d;
            winner_q       <= winner_d;
            win_line_q     <= win_line_d;
            draw_q         <= draw_d;
            illegal_q      <= illegal_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign winner_valid = winner_valid_q;
    assign winner       = winner_q;
    assign win_line     = win_line_q;
    assign draw         = draw_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_ttt_referee.sv
// Directed and random checks of ttt_referee against a reference judging model.
module tb_ttt_referee;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] valid;
    logic [8:0] symbol;
    logic       busy;
    logic       done;
    logic       winner_valid;
    logic       winner;
    logic [2:0] win_line;
    logic       draw;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       wv;
        logic       w;
        logic [2:0] line;
        logic       dr;
        logic       il;
        int         lat;
    } exp_t;

    exp_t sb[$];

    int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
                         '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
                         '{0, 4, 8}, '{2, 4, 6}};

    ttt_referee #(.FIRST_SYMBOL(1'b0)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .valid        (valid),
        .symbol       (symbol),
        .busy         (busy),
        .done         (done),
        .winner_valid (winner_valid),
        .winner       (winner),
        .win_line     (win_line),
        .draw         (draw),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [8:0] v, input logic [8:0] s);
        exp_t e;
        int   a, b, c, cf, cs;
        bit   found;
        e.wv  = 1'b0;
        e.w   = 1'b0;
        e.line = 3'd0;
        e.dr  = (v == 9'h1FF);
        e.il  = 1'b0;
        e.lat = 9;
`ifdef TTT_REFEREE_ILLEGAL_CHECK_EN
        cf = 0;
        cs = 0;
        for (int i = 0; i < 9; i++) begin
            if (v[i] && (s[i] == 1'b0)) cf++;
            if (v[i] && (s[i] == 1'b1)) cs++;
        end
        if (!((cf - cs == 0) || (cf - cs == 1))) begin
            e.il  = 1'b1;
            e.dr  = 1'b0;
            e.lat = 1;
            return e;
        end
`endif
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a = lines[k][0];
            b = lines[k][1];
            c = lines[k][2];
            if (!found && v[a] && v[b] && v[c] && (s[a] == s[b]) && (s[b] == s[c])) begin
                found  = 1'b1;
                e.wv   = 1'b1;
                e.w    = s[a];
                e.line = k[2:0];
                e.dr   = 1'b0;
                e.lat  = k + 1;
            end
        end
        return e;
    endfunction

    // Start a judgement; optionally change inputs and re-raise start before edge chg_edge.
    task automatic run_board(input logic [8:0] v, input logic [8:0] s,
                             input int chg_edge, input logic [8:0] v2, input logic [8:0] s2);
        exp_t e;
        bit   got;
        sb.push_back(model(v, s));
        valid  = v;
        symbol = s;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_after_start", {31'd0, done}, 32'd0);
        got = 1'b0;
        for (int i = 1; i <= 12 && !got; i++) begin
            if (i == chg_edge) begin
                valid  = v2;
                symbol = s2;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                got = 1'b1;
                e = sb.pop_front();
                check("latency",      i,                          e.lat);
                check("winner_valid", {31'd0, winner_valid},      {31'd0, e.wv});
                check("winner",       {31'd0, winner},            {31'd0, e.w});
                check("win_line",     {29'd0, win_line},          {29'd0, e.line});
                check("draw",         {31'd0, draw},              {31'd0, e.dr});
                check("illegal",      {31'd0, illegal},           {31'd0, e.il});
                check("busy_at_done", {31'd0, busy},              32'd0);
            end else begin
                check("busy_during_scan", {31'd0, busy}, 32'd1);
            end
        end
        start = 1'b0;
        check("done_timeout", {31'd0, got}, 32'd1);
        if (!got) void'(sb.pop_front());
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    {31'd0, busy},         32'd0);
        check({tag, "_done"},    {31'd0, done},         32'd0);
        check({tag, "_wv"},      {31'd0, winner_valid}, 32'd0);
        check({tag, "_winner"},  {31'd0, winner},       32'd0);
        check({tag, "_line"},    {29'd0, win_line},     32'd0);
        check({tag, "_draw"},    {31'd0, draw},         32'd0);
        check({tag, "_illegal"}, {31'd0, illegal},      32'd0);
    endtask

    initial begin
        logic [8:0] rv, rs;
        reset  = 1'b1;
        start  = 1'b0;
        valid  = 9'd0;
        symbol = 9'd0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Row-0 win, then hold results for a cycle with done dropping
        run_board(9'b000011111, 9'b000011000, 0, 9'd0, 9'd0);
        tick();
        check("hold_done",     {31'd0, done},         32'd0);
        check("hold_wv",       {31'd0, winner_valid}, 32'd1);
        check("hold_line",     {29'd0, win_line},     32'd0);
        check("hold_busy",     {31'd0, busy},         32'd0);

        // Anti-diagonal win, draw, snapshot with ignored mid-scan start
        run_board(9'b001010111, 9'b000000011, 0, 9'd0, 9'd0);
        run_board(9'h1FF, 9'b001110010, 0, 9'd0, 9'd0);
        run_board(9'd0, 9'd0, 2, 9'b000011111, 9'b000011000);
        run_board(9'b000000111, 9'b000000111, 0, 9'd0, 9'd0);

        // Reset mid-scan aborts without a done pulse
        valid  = 9'b001010111;
        symbol = 9'b000000011;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_done_after_reset", {31'd0, done}, 32'd0);
        end
        run_board(9'h1FF, 9'b001110010, 0, 9'd0, 9'd0);

        // Reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_all_zero("reset_start");
        tick();
        check("reset_start_busy", {31'd0, busy}, 32'd0);

        for (int n = 0; n < 8; n++) begin
            rv = 9'($urandom);
            rs = 9'($urandom);
            run_board(rv, rs, 0, 9'd0, 9'd0);
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
